// File: rtl/conv_pkg.sv
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared types and constants for the convolution result datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

   localparam int CONV_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2
   } coll_state_e;

endpackage : conv_pkg

`default_nettype wire

// File: rtl/conv_result_ram.sv
// ============================================================================
// Module  : conv_result_ram
// Brief   : DEPTH x DATA_W buffer, one synchronous write and one registered read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
   end

   // The read register doubles as the visible output word, so it holds when not enabled.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst)         rd_data_q <= '0;
      else if (i_rd_en) rd_data_q <= mem[i_rd_addr];
   end

   assign o_rd_data = rd_data_q;

endmodule : conv_result_ram

`default_nettype wire

// File: rtl/conv_result_collector.sv
// ============================================================================
// Module  : conv_result_collector
// Brief   : Buffers conv_fix results until end_conv, then drains them over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_collector
   import conv_pkg::*;
#(
   parameter int DATA_W = CONV_DATA_W,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [DATA_W-1:0] result,
   input  logic              out_valid,
   input  logic              end_conv,
   input  logic              clear,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              done
);

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

   coll_state_e       state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              rd_valid_q, rd_valid_d;

   logic              w_ram_wr_en;
   logic              w_ram_rd_en;
   logic [ADDR_W-1:0] w_ram_rd_addr;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_CAPTURE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      rd_valid_d    = rd_valid_q;
      w_ram_wr_en   = 1'b0;
      w_ram_rd_en   = 1'b0;
      w_ram_rd_addr = rd_ptr_q;

      if (clear) begin
         state_d    = ST_CAPTURE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         rd_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_CAPTURE: begin
               if (out_valid) begin
                  if (count_q != c_depth) begin
                     w_ram_wr_en = 1'b1;
                     wr_ptr_d    = wr_ptr_q + 1'b1;
                     count_d     = count_q + 1'b1;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               // count_d already includes a word captured alongside end_conv.
               if (end_conv) state_d = (count_d != '0) ? ST_DRAIN : ST_DONE;
            end
            ST_DRAIN: begin
               if (out_valid) overflow_d = 1'b1;
               if (!rd_valid_q) begin
                  // First DRAIN cycle: fetch word 0 (rd_ptr is still zero).
                  w_ram_rd_en = 1'b1;
                  rd_valid_d  = 1'b1;
               end else if (rd_ready) begin
                  if ({1'b0, rd_ptr_q} == count_q - 1'b1) begin
                     rd_valid_d = 1'b0;
                     state_d    = ST_DONE;
                  end else begin
                     rd_ptr_d      = rd_ptr_q + 1'b1;
                     w_ram_rd_en   = 1'b1;
                     w_ram_rd_addr = rd_ptr_d;
                  end
               end
            end
            ST_DONE: begin
               if (out_valid) overflow_d = 1'b1;
               rd_valid_d = 1'b0;
            end
            default: state_d = ST_CAPTURE;
         endcase
      end
   end

   conv_result_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock     (clock),
      .rst       (rst),
      .i_wr_en   (w_ram_wr_en),
      .i_wr_addr (wr_ptr_q),
      .i_wr_data (result),
      .i_rd_en   (w_ram_rd_en),
      .i_rd_addr (w_ram_rd_addr),
      .o_rd_data (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign done     = (state_q == ST_DONE);

endmodule : conv_result_collector

`default_nettype wire

// File: tb/tb_conv_result_collector.sv
// ============================================================================
// Module  : tb_conv_result_collector
// Brief   : Directed self-checking bench for conv_result_collector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_result_collector;

   logic        clock;
   logic        rst;
   logic [31:0] result;
   logic        out_valid;
   logic        end_conv;
   logic        clear;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  count;
   logic        overflow;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   conv_result_collector #(
      .DATA_W (32),
      .DEPTH  (16),
      .ADDR_W (4)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .result    (result),
      .out_valid (out_valid),
      .end_conv  (end_conv),
      .clear     (clear),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .count     (count),
      .overflow  (overflow),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      chk({tag, "_rd_data"},  rd_data,           32'd0);
      chk({tag, "_count"},    {27'd0, count},    32'd0);
      chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
      chk({tag, "_done"},     {31'd0, done},     32'd0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   // Streams n words base+i*step, end_conv on the last; returns at the negedge after it.
   task automatic stream(input int n, input logic [31:0] base, input logic [31:0] step);
      for (int i = 0; i < n; i++) begin
         result    = base + step * i;
         out_valid = 1'b1;
         end_conv  = (i == n - 1);
         cyc();
      end
      out_valid = 1'b0;
      end_conv  = 1'b0;
      result    = 32'd0;
   endtask

   initial begin
      logic [31:0] exp_w;
      int          idx;

      rst = 1'b1; result = '0; out_valid = 1'b0; end_conv = 1'b0;
      clear = 1'b0; rd_ready = 1'b0;

      // 1: asynchronous reset between clock edges
      #2 rst = 1'b0;
      #1 chk_idle("async_reset");
      cyc();
      rst = 1'b1;
      cyc();

      // 2: five words, end_conv with the fifth, rd_ready held high
      stream(5, 32'h20, 32'h20);
      chk("t2_count", {27'd0, count}, 32'd5);
      chk("t2_no_valid_on_entry", {31'd0, rd_valid}, 32'd0);
      rd_ready = 1'b1;
      cyc();
      for (int k = 0; k < 5; k++) begin
         exp_w = 32'h20 * (k + 1);
         chk("t2_rd_valid", {31'd0, rd_valid}, 32'd1);
         chk("t2_rd_data", rd_data, exp_w);
         cyc();
      end
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_rd_valid_after", {31'd0, rd_valid}, 32'd0);
      rd_ready = 1'b0;

      // 3: same stream with rd_ready alternating
      do_clear();
      chk("t3_clear_done", {31'd0, done}, 32'd0);
      chk("t3_clear_count", {27'd0, count}, 32'd0);
      stream(5, 32'h20, 32'h20);
      cyc();
      idx = 0;
      for (int c = 0; c < 9; c++) begin
         exp_w = 32'h20 * (idx + 1);
         chk("t3_rd_valid", {31'd0, rd_valid}, 32'd1);
         chk("t3_rd_data", rd_data, exp_w);
         rd_ready = (c % 2 == 0);
         cyc();
         if (c % 2 == 0) idx++;
      end
      rd_ready = 1'b0;
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_rd_valid_after", {31'd0, rd_valid}, 32'd0);

      // 4: twenty words into a sixteen-word buffer
      do_clear();
      stream(20, 32'h1000, 32'h1);
      chk("t4_count", {27'd0, count}, 32'd16);
      chk("t4_overflow", {31'd0, overflow}, 32'd1);
      rd_ready = 1'b1;
      cyc();
      for (int k = 0; k < 16; k++) begin
         chk("t4_rd_valid", {31'd0, rd_valid}, 32'd1);
         chk("t4_rd_data", rd_data, 32'h1000 + k);
         cyc();
      end
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_count_hold", {27'd0, count}, 32'd16);
      rd_ready = 1'b0;

      // 5: end_conv with nothing captured, then a stray word in DONE
      do_clear();
      chk("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
      end_conv = 1'b1;
      cyc();
      end_conv = 1'b0;
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_count", {27'd0, count}, 32'd0);
      rd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("t5_no_rd_valid", {31'd0, rd_valid}, 32'd0);
         cyc();
      end
      rd_ready  = 1'b0;
      result    = 32'hBEEF;
      out_valid = 1'b1;
      cyc();
      out_valid = 1'b0;
      chk("t5_overflow_in_done", {31'd0, overflow}, 32'd1);
      chk("t5_count_after_stray", {27'd0, count}, 32'd0);

      // 6: clear after two of five drained (clear beats a same-cycle word), then a 3-word run
      do_clear();
      stream(5, 32'h20, 32'h20);
      rd_ready = 1'b1;
      cyc();
      chk("t6_first", rd_data, 32'h20);
      cyc();
      chk("t6_second", rd_data, 32'h40);
      rd_ready  = 1'b0;
      clear     = 1'b1;
      result    = 32'hDEAD;
      out_valid = 1'b1;
      cyc();
      clear     = 1'b0;
      out_valid = 1'b0;
      chk("t6_clear_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("t6_clear_count", {27'd0, count}, 32'd0);
      stream(3, 32'h111, 32'h111);
      chk("t6_count", {27'd0, count}, 32'd3);
      chk("t6_overflow", {31'd0, overflow}, 32'd0);
      rd_ready = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++) begin
         chk("t6_rd_valid", {31'd0, rd_valid}, 32'd1);
         chk("t6_rd_data", rd_data, 32'h111 * (k + 1));
         cyc();
      end
      chk("t6_done", {31'd0, done}, 32'd1);
      rd_ready = 1'b0;

      // 7: reset asserted mid-DRAIN
      do_clear();
      stream(2, 32'h5A5A0001, 32'h1);
      cyc();
      chk("t7_pre_rd_valid", {31'd0, rd_valid}, 32'd1);
      #2 rst = 1'b0;
      #1 chk_idle("t7_reset_mid_drain");
      cyc();
      rst = 1'b1;
      cyc();
      chk_idle("t7_after_release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_conv_result_collector

`default_nettype wire
